// File: rtl/key_debounce_scheduler.sv
// Debounces a bank of pushbuttons with one shared tick timer, serving keys whose
// synchronized level differs from the committed level in round-robin order.
module key_debounce_scheduler #(
  parameter int N_KEYS       = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 15,
  parameter int IDX_W        = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              busy,
  output logic [IDX_W-1:0]  active_idx
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

  typedef enum logic [1:0] {SCAN, TIMING, COMMIT} state_t;

  state_t            state, state_d;
  logic [N_KEYS-1:0] s1, s2, mm;
  logic [N_KEYS-1:0] level_d, press_d, release_d;
  logic [IDX_W-1:0]  rr, rr_d, idx_d, pick, next_idx;
  logic              pick_valid;
  logic              cand, cand_d;
  logic [DIV_W-1:0]  div, div_d;
  logic [CNT_W-1:0]  tcnt, tcnt_d;
  logic              tick;

  assign mm       = s2 ^ key_level;
  assign tick     = (div == DIV_W'(TICK_DIV - 1));
  assign busy     = (state != SCAN);
  assign next_idx = (active_idx == IDX_W'(N_KEYS - 1)) ? '0 : active_idx + IDX_W'(1);

  // Circular first-set search starting at the round-robin pointer
  always_comb begin
    int j;
    logic [IDX_W-1:0] jj;
    pick       = '0;
    pick_valid = 1'b0;
    j          = 0;
    jj         = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      j  = (int'(rr) + i) % N_KEYS;
      jj = IDX_W'(j);
      if (!pick_valid && mm[jj]) begin
        pick       = jj;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state;
    rr_d      = rr;
    idx_d     = active_idx;
    cand_d    = cand;
    div_d     = div;
    tcnt_d    = tcnt;
    level_d   = key_level;
    press_d   = '0;
    release_d = '0;
    case (state)
      SCAN: begin
        if (pick_valid) begin
          idx_d   = pick;
          cand_d  = s2[pick];
          div_d   = '0;
          tcnt_d  = '0;
          state_d = TIMING;
        end
      end
      TIMING: begin
        // A level change on the timed key wins over a coincident tick
        if (s2[active_idx] != cand) begin
          rr_d    = next_idx;
          state_d = SCAN;
        end else begin
          div_d = tick ? '0 : div + DIV_W'(1);
          if (tick) begin
            if (tcnt == CNT_W'(STABLE_TICKS - 1)) state_d = COMMIT;
            else                                   tcnt_d  = tcnt + CNT_W'(1);
          end
        end
      end
      COMMIT: begin
        level_d[active_idx]   = cand;
        press_d[active_idx]   = cand;
        release_d[active_idx] = ~cand;
        rr_d                  = next_idx;
        state_d               = SCAN;
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SCAN;
    else      state <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1          <= '0;
      s2          <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      active_idx  <= '0;
      rr          <= '0;
      cand        <= 1'b0;
      div         <= '0;
      tcnt        <= '0;
    end else begin
      s1          <= key_in;
      s2          <= s1;
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
      active_idx  <= idx_d;
      rr          <= rr_d;
      cand        <= cand_d;
      div         <= div_d;
      tcnt        <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_key_debounce_scheduler.sv
// Directed bench for key_debounce_scheduler with a pulse scoreboard keyed on cycle number.
module tb_key_debounce_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_in;
  logic [N-1:0] key_level, key_press, key_release;
  logic         busy;
  logic [1:0]   active_idx;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int t0, t1;

  // {press, release, cycle}
  logic [39:0] exp_q[$];

  key_debounce_scheduler #(
    .N_KEYS(N), .TICK_DIV(4), .STABLE_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .busy(busy), .active_idx(active_idx)
  );

  // clock / reset-independent cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input logic [N-1:0] p, input logic [N-1:0] r, input int at);
    exp_q.push_back({p, r, 32'(at)});
  endtask

  task automatic go_edge(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int k);
    go_edge(k);
    @(negedge clk);
  endtask

  // scoreboard: every pulse must match the head of the queue, including its cycle
  always @(negedge clk) begin
    logic [39:0] obs, exp;
    if ((key_press | key_release) != '0) begin
      obs = {key_press, key_release, 32'(cyc)};
      if (exp_q.size() == 0) exp = {8'h00, 32'(cyc)};
      else                   exp = exp_q.pop_front();
      chk("pulse", {24'h0, obs}, {24'h0, exp});
    end
  end

  initial begin
    // reset with all keys held down
    rst    = 1'b0;
    key_in = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_level", key_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", active_idx, 0);
    chk("rst_pulses", {key_press, key_release}, 0);
    go_edge(5);
    rst = 1'b1;
    t0  = cyc;
    @(negedge clk);
    chk("post_rst_level", key_level, 0);
    chk("post_rst_busy", busy, 0);
    expect_pulse(4'b0001, 4'b0000, t0 + 16);
    at_neg(t0 + 16);
    chk("first_commit_level", key_level, 4'b0001);
    at_neg(t0 + 17);
    chk("key1_timing_idx", active_idx, 1);
    chk("key1_timing_busy", busy, 1);
    // async reset 10 edges into key1's window discards it
    go_edge(t0 + 27);
    rst = 1'b0;
    #1;
    chk("async_rst_level", key_level, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_idx", active_idx, 0);
    chk("async_rst_pulses", {key_press, key_release}, 0);
    key_in = 4'b0000;
    go_edge(t0 + 30);
    rst = 1'b1;
    at_neg(t0 + 70);
    chk("quiet_level", key_level, 0);
    chk("quiet_busy", busy, 0);

    // simultaneous keys 0 and 2 with pointer at 0
    go_edge(t0 + 75);
    t0     = cyc;
    key_in = 4'b0101;
    expect_pulse(4'b0001, 4'b0000, t0 + 16);
    expect_pulse(4'b0100, 4'b0000, t0 + 30);
    at_neg(t0 + 2);
    chk("sync_busy_low", busy, 0);
    at_neg(t0 + 3);
    chk("sim_idx0", active_idx, 0);
    chk("sim_busy", busy, 1);
    at_neg(t0 + 17);
    chk("sim_idx2", active_idx, 2);
    at_neg(t0 + 31);
    chk("sim_level", key_level, 4'b0101);
    chk("sim_idle", busy, 0);

    // pointer now at 3: keys 1 and 3 pending, 3 first then wrap to 1
    go_edge(t0 + 35);
    t0     = cyc;
    key_in = 4'b1111;
    expect_pulse(4'b1000, 4'b0000, t0 + 16);
    expect_pulse(4'b0010, 4'b0000, t0 + 30);
    at_neg(t0 + 3);
    chk("rr_idx3", active_idx, 3);
    at_neg(t0 + 17);
    chk("rr_idx1", active_idx, 1);
    at_neg(t0 + 31);
    chk("rr_level", key_level, 4'b1111);

    // clean release of key0
    go_edge(t0 + 35);
    t0     = cyc;
    key_in = 4'b1110;
    expect_pulse(4'b0000, 4'b0001, t0 + 16);
    at_neg(t0 + 3);
    chk("rel_idx", active_idx, 0);
    at_neg(t0 + 17);
    chk("rel_level", key_level, 4'b1110);
    chk("rel_idle", busy, 0);

    // key0 press bounces back mid-window
    go_edge(t0 + 20);
    t0     = cyc;
    key_in = 4'b1111;
    go_edge(t0 + 6);
    key_in = 4'b1110;
    at_neg(t0 + 8);
    chk("bounce_busy_still", busy, 1);
    at_neg(t0 + 9);
    chk("bounce_abort_busy", busy, 0);
    chk("bounce_level", key_level, 4'b1110);
    go_edge(t0 + 12);
    t1     = cyc;
    key_in = 4'b1111;
    expect_pulse(4'b0001, 4'b0000, t1 + 16);
    // key3 glitches low and back while waiting: no event expected
    go_edge(t1 + 4);
    key_in = 4'b0111;
    go_edge(t1 + 7);
    key_in = 4'b1111;
    at_neg(t1 + 17);
    chk("repress_level", key_level, 4'b1111);
    at_neg(t1 + 30);
    chk("waiting_glitch_idle", busy, 0);

    // reset during key1 release window
    go_edge(t1 + 32);
    t0     = cyc;
    key_in = 4'b1101;
    at_neg(t0 + 3);
    chk("final_idx", active_idx, 1);
    chk("final_busy", busy, 1);
    go_edge(t0 + 13);
    rst = 1'b0;
    #1;
    chk("final_rst_level", key_level, 0);
    chk("final_rst_busy", busy, 0);
    chk("final_rst_idx", active_idx, 0);
    chk("final_rst_pulses", {key_press, key_release}, 0);
    key_in = 4'b0000;
    go_edge(t0 + 16);
    rst = 1'b1;
    at_neg(t0 + 60);
    chk("final_level", key_level, 0);
    chk("final_idle", busy, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
